// File: rtl/alu_pipe.sv
// Execute-stage ALU with registered output, NZCV flags register, shifts and iterative MUL.
// Latency: 1 cycle for non-MUL ops, WIDTH/MUL_STEP cycles for MUL (busy high while iterating).
// Backpressure: in_ready drops while MUL iterates or while a held result is not taken (out_valid && !out_ready).
//
// Ports:
//   clk, rst_n                   clock, synchronous active-low reset
//   in_valid/in_ready            operation handshake; in_op, in_a, in_b, in_set_flags qualify it
//   out_valid/out_ready          result handshake; out_result, out_flags ({N,Z,C,V}) held until taken
//   flags_q                      architectural NZCV register (C feeds ADC/SBC and shift sh=0)
//   busy                         MUL in progress
module alu_pipe #(
    parameter int WIDTH    = 32,
    parameter int MUL_STEP = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_set_flags,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [3:0]       out_flags,
    output logic [3:0]       flags_q,
    output logic             busy
);

    localparam int STEPS = WIDTH / MUL_STEP;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int KW    = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);
    localparam logic [7:0]    W8   = 8'(WIDTH);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_ORR = 4'd3;
    localparam logic [3:0] OP_EOR = 4'd4;
    localparam logic [3:0] OP_ADC = 4'd5;
    localparam logic [3:0] OP_SBC = 4'd6;
    localparam logic [3:0] OP_LSL = 4'd7;
    localparam logic [3:0] OP_LSR = 4'd8;
    localparam logic [3:0] OP_ASR = 4'd9;
    localparam logic [3:0] OP_ROR = 4'd10;
    localparam logic [3:0] OP_MUL = 4'd11;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic accept;
    logic mul_done;

    // multiplier state: shifted multiplicand, consumed multiplier, running sum
    logic [WIDTH-1:0] mc_q, mb_q, acc_q;
    logic [CW-1:0]    cnt_q;
    logic             msf_q;
    logic [WIDTH-1:0] pp, acc_next;
    logic [3:0]       mul_f;

    // single-cycle datapath
    logic [WIDTH-1:0]        alu_r;
    logic [3:0]              alu_f;
    logic                    c, v, cin_c;
    logic [7:0]              sh;
    logic [KW-1:0]           k, kinv;
    logic [WIDTH:0]          sum, ext_l, ext_r;
    logic signed [WIDTH:0]   sext;

    assign in_ready = (state_q == S_IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign busy     = (state_q == S_MUL);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mul_done = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept && in_op == OP_MUL) begin
                    state_d = S_MUL;
                end
            end
            S_MUL: begin
                if (cnt_q == LAST) begin
                    mul_done = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------- MUL step
    always_comb begin
        pp = '0;
        for (int i = 0; i < MUL_STEP; i++) begin
            if (mb_q[i]) begin
                pp = pp + (mc_q << i);
            end
        end
        acc_next = acc_q + pp;
        mul_f    = {acc_next[WIDTH-1], (acc_next == '0), 2'b00};
    end

    // ---------------------------------------------------------------- ALU
    always_comb begin
        cin_c = flags_q[1];
        sh    = in_b[7:0];
        k     = sh[KW-1:0];
        kinv  = '0 - k;
        alu_r = '1;          // reserved opcodes: all ones, C=V=0
        c     = 1'b0;
        v     = 1'b0;
        sum   = '0;
        ext_l = '0;
        ext_r = '0;
        sext  = '0;
        case (in_op)
            OP_ADD, OP_ADC: begin
                sum   = {1'b0, in_a} + {1'b0, in_b}
                      + {{WIDTH{1'b0}}, (in_op == OP_ADC) ? cin_c : 1'b0};
                alu_r = sum[WIDTH-1:0];
                c     = sum[WIDTH];
                v     = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (alu_r[WIDTH-1] != in_a[WIDTH-1]);
            end
            OP_SUB, OP_SBC: begin
                sum   = {1'b0, in_a} + {1'b0, ~in_b}
                      + {{WIDTH{1'b0}}, (in_op == OP_SBC) ? cin_c : 1'b1};
                alu_r = sum[WIDTH-1:0];
                c     = sum[WIDTH];
                v     = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (alu_r[WIDTH-1] != in_a[WIDTH-1]);
            end
            OP_AND: alu_r = in_a & in_b;
            OP_ORR: alu_r = in_a | in_b;
            OP_EOR: alu_r = in_a ^ in_b;
            OP_LSL: begin
                // extra MSB catches the last bit shifted out
                ext_l = {1'b0, in_a} << sh;
                if (sh == 8'd0) begin
                    alu_r = in_a;
                    c     = cin_c;
                end else if (sh <= W8) begin
                    alu_r = ext_l[WIDTH-1:0];
                    c     = ext_l[WIDTH];
                end else begin
                    alu_r = '0;
                end
            end
            OP_LSR: begin
                // extra LSB catches the last bit shifted out
                ext_r = {in_a, 1'b0} >> sh;
                if (sh == 8'd0) begin
                    alu_r = in_a;
                    c     = cin_c;
                end else if (sh <= W8) begin
                    alu_r = ext_r[WIDTH:1];
                    c     = ext_r[0];
                end else begin
                    alu_r = '0;
                end
            end
            OP_ASR: begin
                sext = $signed({in_a, 1'b0}) >>> sh;
                if (sh == 8'd0) begin
                    alu_r = in_a;
                    c     = cin_c;
                end else if (sh < W8) begin
                    alu_r = sext[WIDTH:1];
                    c     = sext[0];
                end else begin
                    alu_r = {WIDTH{in_a[WIDTH-1]}};
                    c     = in_a[WIDTH-1];
                end
            end
            OP_ROR: begin
                if (sh == 8'd0) begin
                    alu_r = in_a;
                    c     = cin_c;
                end else begin
                    // kinv = WIDTH-k mod WIDTH; for k=0 both halves equal in_a
                    alu_r = (in_a >> k) | (in_a << kinv);
                    c     = alu_r[WIDTH-1];
                end
            end
            OP_MUL: alu_r = '0;  // result comes from the iterative path
            default: ;
        endcase
        alu_f = {alu_r[WIDTH-1], (alu_r == '0), c, v};
    end

    // ---------------------------------------------------------------- datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mc_q       <= '0;
            mb_q       <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            msf_q      <= 1'b0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_flags  <= '0;
            flags_q    <= '0;
        end else begin
            if (accept && in_op == OP_MUL) begin
                mc_q  <= in_a;
                mb_q  <= in_b;
                acc_q <= '0;
                cnt_q <= '0;
                msf_q <= in_set_flags;
            end else if (state_q == S_MUL) begin
                acc_q <= acc_next;
                mc_q  <= mc_q << MUL_STEP;
                mb_q  <= mb_q >> MUL_STEP;
                cnt_q <= cnt_q + CW'(1);
            end

            // out_valid is always 0 when a MUL finishes: accepting it drained the output
            if (accept && in_op != OP_MUL) begin
                out_valid  <= 1'b1;
                out_result <= alu_r;
                out_flags  <= alu_f;
                if (in_set_flags) begin
                    flags_q <= alu_f;
                end
            end else if (mul_done) begin
                out_valid  <= 1'b1;
                out_result <= acc_next;
                out_flags  <= mul_f;
                if (msf_q) begin
                    flags_q <= mul_f;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
module tb_alu_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_op = 4'd0;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        in_set_flags = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic [3:0]  out_flags;
    logic [3:0]  flags_q;
    logic        busy;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(32), .MUL_STEP(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_set_flags(in_set_flags),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_flags(out_flags),
        .flags_q(flags_q), .busy(busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] r;
        logic [3:0]  f;
        logic [3:0]  fq;
    } exp_t;

    exp_t       q[$];
    logic [3:0] m_flags = 4'd0;
    bit         rand_bp = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: {N,Z,C,V, result} straight from the arithmetic meaning of each opcode.
    function automatic logic [35:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [3:0] fl);
        logic [31:0] r;
        logic        c, v, cin;
        longint      u, s, ci;
        int          sh, kk;
        logic [63:0] p;
        cin = fl[1];
        sh  = int'(b[7:0]);
        r = '1; c = 1'b0; v = 1'b0;
        case (op)
            4'd0, 4'd5: begin
                ci = (op == 4'd5) ? longint'(cin) : 0;
                u  = longint'(a) + longint'(b) + ci;
                s  = longint'($signed(a)) + longint'($signed(b)) + ci;
                r  = u[31:0];
                c  = u[32];
                v  = (s != longint'($signed(r)));
            end
            4'd1, 4'd6: begin
                ci = (op == 4'd6) ? longint'(cin) : 1;
                u  = longint'(a) - longint'(b) - 1 + ci;
                s  = longint'($signed(a)) - longint'($signed(b)) - 1 + ci;
                r  = u[31:0];
                c  = (u >= 0);
                v  = (s != longint'($signed(r)));
            end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd7: begin
                if (sh == 0) begin r = a; c = cin; end
                else if (sh <= 32) begin p = 64'(a) << sh; r = p[31:0]; c = a[32-sh]; end
                else r = '0;
            end
            4'd8: begin
                if (sh == 0) begin r = a; c = cin; end
                else if (sh <= 32) begin p = 64'(a) >> sh; r = p[31:0]; c = a[sh-1]; end
                else r = '0;
            end
            4'd9: begin
                if (sh == 0) begin r = a; c = cin; end
                else if (sh < 32) begin u = longint'($signed(a)) >>> sh; r = u[31:0]; c = a[sh-1]; end
                else begin r = {32{a[31]}}; c = a[31]; end
            end
            4'd10: begin
                if (sh == 0) begin r = a; c = cin; end
                else begin kk = sh % 32; p = {a, a} >> kk; r = p[31:0]; c = r[31]; end
            end
            4'd11: begin p = 64'(a) * 64'(b); r = p[31:0]; end
            default: r = '1;
        endcase
        return {r[31], (r == 32'd0), c, v, r};
    endfunction

    task automatic push_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic sf);
        logic [35:0] m;
        exp_t e;
        m = model(op, a, b, m_flags);
        if (sf) m_flags = m[35:32];
        e.r = m[31:0]; e.f = m[35:32]; e.fq = m_flags;
        q.push_back(e);
    endtask

    // Called just after a rising edge; returns just after the accepting edge with in_valid low.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic sf);
        int t;
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_set_flags = sf;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL issue_timeout: in_ready stuck low for op %0d", op);
            @(posedge clk); #1;
            in_valid = 1'b0;
        end else begin
            push_model(op, a, b, sf);
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic issue_chk(input string name, input logic [3:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic sf,
                             input logic [31:0] er, input logic [3:0] ef);
        issue(op, a, b, sf);
        @(negedge clk);
        chk({name, "_result"}, out_result, er);
        chk({name, "_flags"}, out_flags, ef);
        @(posedge clk); #1;
    endtask

    // Compare process: every accepted result against the model, in order.
    always @(negedge clk) begin : compare
        exp_t e;
        if (rst_n && out_valid) begin
            if (q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL spurious_out_valid: result %0h with nothing expected", out_result);
            end else if (out_ready) begin
                e = q.pop_front();
                chk("scb_result", out_result, e.r);
                chk("scb_flags", out_flags, e.f);
                chk("scb_flags_q", flags_q, e.fq);
            end
        end
    end

    always @(posedge clk) begin
        if (rand_bp) begin
            #1;
            out_ready = ($urandom % 4) != 0;
        end
    end

    initial begin
        int bc;
        int t;
        logic [3:0]  op;
        logic [31:0] a, b;

        // reset
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_out_flags", out_flags, 0);
        chk("rst_flags_q", flags_q, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // ADD overflow to zero, flags committed
        issue(4'd0, 32'hFFFF_FFFF, 32'h1, 1'b1);
        @(negedge clk);
        chk("add_result", out_result, 32'h0);
        chk("add_flags", out_flags, 4'b0110);
        chk("add_flags_q", flags_q, 4'b0110);
        @(posedge clk); #1;

        // back-to-back ADD then ADC seeing the fresh carry
        in_valid = 1'b1; in_op = 4'd0; in_a = 32'h8000_0000; in_b = 32'h8000_0000; in_set_flags = 1'b1;
        @(negedge clk);
        chk("b2b_add_ready", in_ready, 1);
        push_model(4'd0, 32'h8000_0000, 32'h8000_0000, 1'b1);
        @(posedge clk); #1;
        in_op = 4'd5; in_a = 32'h1; in_b = 32'h1; in_set_flags = 1'b0;
        @(negedge clk);
        chk("b2b_add_valid", out_valid, 1);
        chk("b2b_add_result", out_result, 32'h0);
        chk("b2b_add_flags", out_flags, 4'b0111);
        chk("b2b_adc_ready", in_ready, 1);
        push_model(4'd5, 32'h1, 32'h1, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_adc_valid", out_valid, 1);
        chk("b2b_adc_result", out_result, 32'h3);
        chk("b2b_adc_flags", out_flags, 4'b0000);
        @(posedge clk); #1;

        // backpressure hold on SUB 5-5
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        issue(4'd1, 32'h5, 32'h5, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_valid", out_valid, 1);
            chk("hold_result", out_result, 32'h0);
            chk("hold_flags", out_flags, 4'b0110);
            chk("hold_in_ready", in_ready, 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        issue(4'd4, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0);
        @(negedge clk);
        chk("release_eor_result", out_result, 32'hFF00_FF00);
        chk("release_eor_flags", out_flags, 4'b1000);
        @(posedge clk); #1;

        // iterative MUL
        issue(4'd11, 32'h0001_0003, 32'h0000_0005, 1'b1);
        bc = 0;
        @(negedge clk);
        while (busy && bc < 100) begin
            bc++;
            chk("mul_in_ready_low", in_ready, 0);
            @(negedge clk);
        end
        chk("mul_busy_cycles", bc, 32);
        chk("mul_valid", out_valid, 1);
        chk("mul_result", out_result, 32'h0005_000F);
        chk("mul_flags", out_flags, 4'b0000);
        @(posedge clk); #1;

        // shift boundaries with C=1
        issue(4'd0, 32'hFFFF_FFFF, 32'h1, 1'b1);
        @(posedge clk); #1;
        issue_chk("lsl0",  4'd7,  32'h8000_0001, 32'd0,  1'b0, 32'h8000_0001, 4'b1010);
        issue_chk("lsr1",  4'd8,  32'h8000_0001, 32'd1,  1'b0, 32'h4000_0000, 4'b0010);
        issue_chk("asr40", 4'd9,  32'h8000_0001, 32'd40, 1'b0, 32'hFFFF_FFFF, 4'b1010);
        issue_chk("ror32", 4'd10, 32'h8000_0001, 32'd32, 1'b0, 32'h8000_0001, 4'b1010);
        issue_chk("lsl33", 4'd7,  32'h8000_0001, 32'd33, 1'b0, 32'h0,         4'b0100);
        issue_chk("sbc",   4'd6,  32'h3,         32'h5,  1'b1, 32'hFFFF_FFFE, 4'b1000);
        issue_chk("rsvd",  4'd13, 32'h1234,      32'h1,  1'b0, 32'hFFFF_FFFF, 4'b1000);

        // random ops under random backpressure, checked by the model
        rand_bp = 1'b1;
        for (int n = 0; n < 60; n++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = (op >= 4'd7 && op <= 4'd10) ? 32'($urandom_range(0, 70)) : $urandom;
            if (n % 7 == 3) a = 32'h8000_0000;
            issue(op, a, b, 1'($urandom % 2));
        end
        rand_bp = 1'b0;
        @(posedge clk); #1 out_ready = 1'b1;
        t = 0;
        while (q.size() != 0 && t < 300) begin
            @(posedge clk);
            t++;
        end
        #1;
        chk("drain_queue_empty", q.size(), 0);

        // reset during MUL iteration
        issue(4'd0, 32'hFFFF_FFFF, 32'h1, 1'b1);
        @(posedge clk); #1;
        issue(4'd11, 32'h1234_5678, 32'h9ABC_DEF1, 1'b1);
        repeat (9) @(posedge clk);
        #1 rst_n = 1'b0;
        q.delete();
        m_flags = 4'd0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk("mrst_out_valid", out_valid, 0);
            chk("mrst_busy", busy, 0);
            chk("mrst_flags_q", flags_q, 0);
            chk("mrst_in_ready", in_ready, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
